line_renderer: RTL and testbench

// - Parametrised line-buffer span renderer: takes one packed pattern word (tile or sprite slice),

---
 rtl/line_renderer_pkg.sv | 34 +++
 rtl/line_renderer_if.sv | 51 +++++
 rtl/line_renderer_attr_buf.sv | 48 ++++
 rtl/line_renderer.sv | 177 +++++++++++++++++
 tb/tb_line_renderer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_renderer_pkg.sv
// Shared definitions for the line renderer.
// Contents:
//   ATTR_SPR/ATTR_PRI  bit positions in the per-pixel attribute word
//   DEF_*              default widths used by the interface and modules
//   state_t            span FSM encoding
//   make_attr()        packs {is_sprite, priority} into an attribute word
package line_renderer_pkg;

    localparam int unsigned ATTR_SPR = 1;
    localparam int unsigned ATTR_PRI = 0;
    localparam int unsigned ATTR_W   = 2;

    localparam int unsigned DEF_BPP    = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_PAL_W  = 1;
    localparam int unsigned DEF_IDX_W  = 8;
    localparam int unsigned DEF_LINE_W = 256;

    typedef logic [ATTR_W-1:0] attr_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    function automatic attr_t make_attr(input logic spr, input logic pri);
        attr_t a;
        a           = '0;
        a[ATTR_SPR] = spr;
        a[ATTR_PRI] = pri;
        return a;
    endfunction

endpackage

// File: rtl/line_renderer_if.sv
// Span request channel from the tile/sprite fetch engine to the line renderer.
// Signals:
//   render_valid/render_ready  handshake, span accepted when both high
//   render_idx                 line index of the first pixel
//   render_data                packed pixels, leftmost pixel in the MSBs
//   is_sprite/hflip/hzoom      span kind and horizontal modifiers
//   palette/render_priority    attributes carried into the line buffer
// Modports: master (fetch engine), slave (renderer).
interface line_renderer_if
    import line_renderer_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAL_W  = DEF_PAL_W
) ();

    logic              render_valid;
    logic              render_ready;
    logic [IDX_W-1:0]  render_idx;
    logic [DATA_W-1:0] render_data;
    logic              is_sprite;
    logic              hflip;
    logic              hzoom;
    logic [PAL_W-1:0]  palette;
    logic              render_priority;

    modport master (
        output render_valid,
        output render_idx,
        output render_data,
        output is_sprite,
        output hflip,
        output hzoom,
        output palette,
        output render_priority,
        input  render_ready
    );

    modport slave (
        input  render_valid,
        input  render_idx,
        input  render_data,
        input  is_sprite,
        input  hflip,
        input  hzoom,
        input  palette,
        input  render_priority,
        output render_ready
    );

endinterface

// File: rtl/line_renderer_attr_buf.sv
// Per-pixel attribute store (2^IDX_W entries of {is_sprite, priority}).
// One write port, one synchronous read port. When the read address equals the
// address written in the same cycle, the new data is forwarded so that a pixel
// written on one cycle is seen correctly if it is read back on the next.
// Ports:
//   clk, reset   clock, async active-high reset (read register only)
//   we/waddr/wdata  write port
//   raddr        read address, sampled at the clock edge
//   rdata        registered read data
module line_renderer_attr_buf
    import line_renderer_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  attr_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output attr_t            rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    attr_t mem [DEPTH];
    attr_t rdata_q;

    // Storage array is a plain RAM: no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata_q <= wdata;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_renderer.sv
// Line-buffer span renderer. Accepts one packed pattern word per span, unpacks
// it into NPIX pixels (2*NPIX cycles with hzoom) and emits one {palette, colour}
// line-buffer write per clock. Sprite pixels are gated by the stored attribute
// of the target pixel; sprite-on-sprite hits raise a collision pulse.
// Ports:
//   clk, reset     clock, async active-high reset
//   req            span request channel (slave side)
//   busy           span in progress
//   last_pixel     pulse, final pixel of the span is on wridx
//   spr_collision  pulse, opaque sprite pixel over an existing sprite pixel
//   wridx/wrdata/wren  line buffer write port
module line_renderer
    import line_renderer_pkg::*;
#(
    parameter int unsigned BPP    = DEF_BPP,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAL_W  = DEF_PAL_W,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned LINE_W = DEF_LINE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    line_renderer_if.slave       req,
    output logic                 busy,
    output logic                 last_pixel,
    output logic                 spr_collision,
    output logic [IDX_W-1:0]     wridx,
    output logic [PAL_W+BPP-1:0] wrdata,
    output logic                 wren
);

    localparam int unsigned NPIX  = DATA_W / BPP;
    localparam int unsigned CNT_W = $clog2(2 * NPIX);

    if ((DATA_W % BPP) != 0) begin : g_bad_cfg
        $error("DATA_W must be a multiple of BPP");
    end

    // Span state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PAL_W-1:0]  pal_q, pal_d;
    logic              spr_q, spr_d;
    logic              hflip_q, hflip_d;
    logic              hzoom_q, hzoom_d;
    logic              pri_q, pri_d;

    logic              active;
    logic              last_emit;
    logic              accept;
    logic              in_range;
    logic              opaque;
    logic              sprite_ok;
    logic [CNT_W-1:0]  last_cnt;
    logic [CNT_W-1:0]  slot;
    logic [DATA_W-1:0] shifted;
    logic [BPP-1:0]    colour;
    attr_t             attr_rd;
    attr_t             attr_wr;

    // ------------------------------------------------------------------
    // Span state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            pal_q   <= '0;
            spr_q   <= 1'b0;
            hflip_q <= 1'b0;
            hzoom_q <= 1'b0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pal_q   <= pal_d;
            spr_q   <= spr_d;
            hflip_q <= hflip_d;
            hzoom_q <= hzoom_d;
            pri_q   <= pri_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and span sequencing
    // ------------------------------------------------------------------
    assign active    = (state_q == StRun);
    assign last_cnt  = hzoom_q ? CNT_W'(2 * NPIX - 1) : CNT_W'(NPIX - 1);
    assign last_emit = active && (cnt_q == last_cnt);

    // Ready on the final emitted cycle so a waiting span follows with no gap.
    assign req.render_ready = !reset && (!active || last_emit);
    assign accept           = req.render_valid && req.render_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pal_d   = pal_q;
        spr_d   = spr_q;
        hflip_d = hflip_q;
        hzoom_d = hzoom_q;
        pri_d   = pri_q;

        if (accept) begin
            state_d = StRun;
            cnt_d   = '0;
            idx_d   = req.render_idx;
            data_d  = req.render_data;
            pal_d   = req.palette;
            spr_d   = req.is_sprite;
            hflip_d = req.hflip;
            hzoom_d = req.hzoom;
            pri_d   = req.render_priority;
        end else if (active) begin
            if (last_emit) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel mux
    // ------------------------------------------------------------------
    always_comb begin
        slot = hzoom_q ? (cnt_q >> 1) : cnt_q;
        if (hflip_q) begin
            slot = CNT_W'(NPIX - 1) - slot;
        end
        // Bring the selected slot to the MSBs: slot 0 is the leftmost pixel.
        shifted = data_q << (32'(slot) * BPP);
        colour  = shifted[DATA_W-1 -: BPP];
    end

    // ------------------------------------------------------------------
    // Attribute buffer: read is addressed with next cycle's index so the
    // attribute of the pixel on wridx is available in the same cycle.
    // ------------------------------------------------------------------
    line_renderer_attr_buf #(
        .IDX_W (IDX_W)
    ) u_attr_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wren),
        .waddr (idx_q),
        .wdata (attr_wr),
        .raddr (idx_d),
        .rdata (attr_rd)
    );

    // ------------------------------------------------------------------
    // Write gating and outputs
    // ------------------------------------------------------------------
    assign opaque    = (colour != '0);
    assign in_range  = (32'(idx_q) < LINE_W);
    assign sprite_ok = opaque && !attr_rd[ATTR_SPR] && !attr_rd[ATTR_PRI];
    assign attr_wr   = make_attr(spr_q, pri_q && opaque);

    assign busy          = active;
    assign last_pixel    = last_emit;
    assign wridx         = idx_q;
    assign wrdata        = {pal_q, colour};
    assign wren          = active && in_range && (!spr_q || sprite_ok);
    // Collision does not depend on whether the sprite pixel is actually written.
    assign spr_collision = active && in_range && spr_q && opaque && attr_rd[ATTR_SPR];

endmodule

// File: tb/tb_line_renderer.sv
module tb_line_renderer;

    logic clk = 1'b0;
    logic reset;

    logic       busy;
    logic       last_pixel;
    logic       spr_collision;
    logic [7:0] wridx;
    logic [4:0] wrdata;
    logic       wren;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc_cnt  = 0;
    int unsigned prev_cyc = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  idx;
        logic        wren;
        logic [4:0]  wd;
        logic        last;
        logic        coll;
    } beat_t;

    beat_t log_q[$];
    beat_t mon_beat;

    always #5 clk = ~clk;

    line_renderer_if #(.IDX_W(8), .DATA_W(32), .PAL_W(1)) rif ();

    line_renderer #(
        .BPP    (4),
        .DATA_W (32),
        .PAL_W  (1),
        .IDX_W  (8),
        .LINE_W (250)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (rif),
        .busy          (busy),
        .last_pixel    (last_pixel),
        .spr_collision (spr_collision),
        .wridx         (wridx),
        .wrdata        (wrdata),
        .wren          (wren)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Log every busy cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy) begin
            mon_beat.cyc  = cyc_cnt;
            mon_beat.idx  = wridx;
            mon_beat.wren = wren;
            mon_beat.wd   = wrdata;
            mon_beat.last = last_pixel;
            mon_beat.coll = spr_collision;
            log_q.push_back(mon_beat);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the request until accepted, then drops valid.
    task automatic send_span(input logic [7:0] idx, input logic [31:0] data, input logic spr,
                             input logic hf, input logic hz, input logic pal, input logic pri);
        int waited = 0;
        rif.render_idx      = idx;
        rif.render_data     = data;
        rif.is_sprite       = spr;
        rif.hflip           = hf;
        rif.hzoom           = hz;
        rif.palette         = pal;
        rif.render_priority = pri;
        rif.render_valid    = 1'b1;
        while (!rif.render_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept", {31'b0, rif.render_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rif.render_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("idle", {31'b0, busy}, 32'd0);
    endtask

    // Expected per-beat values are left-aligned: beat k uses wd byte k and mask bit 15-k.
    task automatic check_span(input string tag, input int n, input logic [7:0] idx0,
                              input logic [127:0] wd, input logic [15:0] en,
                              input logic [15:0] coll, input bit contig);
        beat_t      b;
        logic [7:0] exp_idx;
        logic [7:0] exp_wd;
        check_eq({tag, " beats"}, (log_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
        if (log_q.size() < n) return;
        exp_idx = idx0;
        for (int k = 0; k < n; k++) begin
            b = log_q.pop_front();
            if (k > 0 || contig)
                check_eq($sformatf("%s[%0d] gap", tag, k), b.cyc, prev_cyc + 1);
            prev_cyc = b.cyc;
            check_eq($sformatf("%s[%0d] wridx", tag, k), {24'b0, b.idx}, {24'b0, exp_idx});
            check_eq($sformatf("%s[%0d] wren", tag, k), {31'b0, b.wren}, {31'b0, en[15-k]});
            if (en[15-k]) begin
                exp_wd = wd[127-8*k -: 8];
                check_eq($sformatf("%s[%0d] wrdata", tag, k), {27'b0, b.wd}, {24'b0, exp_wd});
            end
            check_eq($sformatf("%s[%0d] last", tag, k), {31'b0, b.last},
                     (k == n - 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s[%0d] coll", tag, k), {31'b0, b.coll}, {31'b0, coll[15-k]});
            exp_idx = exp_idx + 8'd1;
        end
    endtask

    initial begin
        reset               = 1'b1;
        rif.render_valid    = 1'b0;
        rif.render_idx      = '0;
        rif.render_data     = '0;
        rif.is_sprite       = 1'b0;
        rif.hflip           = 1'b0;
        rif.hzoom           = 1'b0;
        rif.palette         = '0;
        rif.render_priority = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst ready", {31'b0, rif.render_ready}, 32'd0);
        check_eq("rst busy", {31'b0, busy}, 32'd0);
        check_eq("rst wren", {31'b0, wren}, 32'd0);
        check_eq("rst last", {31'b0, last_pixel}, 32'd0);
        check_eq("rst coll", {31'b0, spr_collision}, 32'd0);
        check_eq("rst wridx", {24'b0, wridx}, 32'd0);
        check_eq("rst wrdata", {27'b0, wrdata}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("ready after rst", {31'b0, rif.render_ready}, 32'd1);
        @(negedge clk);

        // Plain tile, then the same span flipped with palette 1
        send_span(8'h10, 32'h12345670, 0, 0, 0, 0, 0);
        wait_idle();
        check_span("tile", 8, 8'h10, {64'h0102030405060700, 64'h0}, {8'hFF, 8'h0}, 16'h0, 0);
        send_span(8'h10, 32'h12345670, 0, 1, 0, 1, 0);
        wait_idle();
        check_span("hflip", 8, 8'h10, {64'h1017161514131211, 64'h0}, {8'hFF, 8'h0}, 16'h0, 0);

        // Sprite over a priority tile: nothing written, no collision
        send_span(8'h20, 32'h11111111, 0, 0, 0, 0, 1);
        wait_idle();
        check_span("pri tile", 8, 8'h20, {64'h0101010101010101, 64'h0}, {8'hFF, 8'h0},
                   16'h0, 0);
        send_span(8'h20, 32'h0F000000, 1, 0, 0, 0, 0);
        wait_idle();
        check_span("spr/pri", 8, 8'h20, 128'h0, 16'h0, 16'h0, 0);

        // Clear 0x40..0x4F with transparent tiles, then two overlapping sprites back-to-back
        send_span(8'h40, 32'h00000000, 0, 0, 0, 0, 0);
        send_span(8'h48, 32'h00000000, 0, 0, 0, 0, 0);
        wait_idle();
        check_span("clr0", 8, 8'h40, 128'h0, {8'hFF, 8'h0}, 16'h0, 0);
        check_span("clr1", 8, 8'h48, 128'h0, {8'hFF, 8'h0}, 16'h0, 1);
        send_span(8'h40, 32'h11111111, 1, 0, 0, 0, 0);
        send_span(8'h44, 32'h22222222, 1, 0, 0, 0, 0);
        wait_idle();
        check_span("sprA", 8, 8'h40, {64'h0101010101010101, 64'h0}, {8'hFF, 8'h0}, 16'h0, 0);
        check_span("sprB", 8, 8'h44, {64'h0000000002020202, 64'h0}, {8'h0F, 8'h0},
                   {8'hF0, 8'h0}, 1);

        // Clip boundary at LINE_W=250: 0xF9 written, 0xFA onwards suppressed
        send_span(8'hF6, 32'h11111111, 0, 0, 0, 0, 0);
        wait_idle();
        check_span("clip", 8, 8'hF6, {64'h0101010101010101, 64'h0}, {8'hF0, 8'h0}, 16'h0, 0);

        // hzoom with wrap, followed back-to-back by a plain tile
        send_span(8'hFC, 32'h12345678, 0, 0, 1, 0, 0);
        send_span(8'h50, 32'h9ABCDEF0, 0, 0, 0, 0, 0);
        wait_idle();
        check_span("zoom", 16, 8'hFC, 128'h01010202030304040505060607070808, 16'h0FFF,
                   16'h0, 0);
        check_span("b2b", 8, 8'h50, {64'h090A0B0C0D0E0F00, 64'h0}, {8'hFF, 8'h0}, 16'h0, 1);

        // Reset in the middle of a span
        send_span(8'h60, 32'h11111111, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst busy", {31'b0, busy}, 32'd0);
        check_eq("midrst wren", {31'b0, wren}, 32'd0);
        check_eq("midrst last", {31'b0, last_pixel}, 32'd0);
        check_eq("midrst coll", {31'b0, spr_collision}, 32'd0);
        check_eq("midrst ready", {31'b0, rif.render_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        #1;
        check_eq("ready after midrst", {31'b0, rif.render_ready}, 32'd1);
        @(negedge clk);
        send_span(8'h60, 32'hFEDCBA98, 0, 0, 0, 1, 0);
        wait_idle();
        check_span("post-rst", 8, 8'h60, {64'h1F1E1D1C1B1A1918, 64'h0}, {8'hFF, 8'h0},
                   16'h0, 0);
        check_eq("log empty", log_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
